// File: rtl/time_counter.sv
// Time-of-day counter: prescaled one-second tick driving SEC/MIN/HOUR with full carry,
// plus a SET mode where button edges adjust minutes and hours without carry.
module time_counter #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       clear,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [5:0] hour,
  output logic       tick,
  output logic [1:0] mode
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0] SEC_LAST  = 6'd59;
  localparam logic [5:0] MIN_LAST  = 6'd59;
  localparam logic [5:0] HOUR_LAST = 6'd23;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_SET   = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          count_en;
  logic          adjust_en;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic [5:0]    sec_d;
  logic [5:0]    min_d;
  logic [5:0]    hour_d;
  logic          tick_d;
  logic          inc_min_q;
  logic          inc_hour_q;
  logic          rise_min;
  logic          rise_hour;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_PAUSE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: SET_MODE outranks RUN, any transition allowed
  always_comb begin
    state_d = ST_PAUSE;
    if (set_mode) begin
      state_d = ST_SET;
    end else if (run) begin
      state_d = ST_RUN;
    end
  end

  // Counter actions follow the registered state only
  always_comb begin
    count_en  = 1'b0;
    adjust_en = 1'b0;
    case (state_q)
      ST_RUN:  count_en  = 1'b1;
      ST_SET:  adjust_en = 1'b1;
      default: ;
    endcase
  end

  assign mode = state_q;

  // History resets high so a button held through reset yields no edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inc_min_q  <= 1'b1;
      inc_hour_q <= 1'b1;
    end else begin
      inc_min_q  <= inc_min;
      inc_hour_q <= inc_hour;
    end
  end

  assign rise_min  = inc_min & ~inc_min_q;
  assign rise_hour = inc_hour & ~inc_hour_q;

  // Next time value: clear, then run-mode carry chain or set-mode adjust
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec;
    min_d   = min;
    hour_d  = hour;
    tick_d  = 1'b0;
    if (clear) begin
      presc_d = '0;
      sec_d   = '0;
      min_d   = '0;
      hour_d  = '0;
    end else if (count_en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (sec == SEC_LAST) begin
          sec_d = '0;
          if (min == MIN_LAST) begin
            min_d  = '0;
            hour_d = (hour == HOUR_LAST) ? 6'd0 : hour + 6'd1;
          end else begin
            min_d = min + 6'd1;
          end
        end else begin
          sec_d = sec + 6'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else if (adjust_en) begin
      presc_d = '0;
      sec_d   = '0;
      if (rise_min) begin
        min_d = (min == MIN_LAST) ? 6'd0 : min + 6'd1;
      end
      if (rise_hour) begin
        hour_d = (hour == HOUR_LAST) ? 6'd0 : hour + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      sec     <= '0;
      min     <= '0;
      hour    <= '0;
      tick    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec     <= sec_d;
      min     <= min_d;
      hour    <= hour_d;
      tick    <= tick_d;
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: seconds-of-day reference model checked every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_time_counter;

  localparam int unsigned TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       set_mode;
  logic       inc_min;
  logic       inc_hour;
  logic       clear;
  logic [5:0] sec;
  logic [5:0] min;
  logic [5:0] hour;
  logic       tick;
  logic [1:0] mode;

  int total = 0;
  int bad   = 0;
  bit chk   = 1'b0;

  // Reference: time as seconds-of-day plus prescaler count and mode
  int m_sod   = 0;
  int m_presc = 0;
  int m_mode  = 0;
  int m_tick  = 0;
  bit m_pmin  = 1'b1;
  bit m_phour = 1'b1;

  time_counter #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .set_mode(set_mode),
    .inc_min(inc_min), .inc_hour(inc_hour), .clear(clear),
    .sec(sec), .min(min), .hour(hour), .tick(tick), .mode(mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bit rm;
    bit rh;
    int h;
    int m;
    if (!rst_n) begin
      m_sod = 0; m_presc = 0; m_mode = 0; m_tick = 0;
      m_pmin = 1'b1; m_phour = 1'b1;
    end else begin
      rm = inc_min && !m_pmin;
      rh = inc_hour && !m_phour;
      m_pmin = inc_min;
      m_phour = inc_hour;
      m_tick = 0;
      if (clear) begin
        m_sod = 0;
        m_presc = 0;
      end else if (m_mode == 1) begin
        m_presc = m_presc + 1;
        if (m_presc == TICK_DIV) begin
          m_presc = 0;
          m_sod = (m_sod + 1) % 86400;
          m_tick = 1;
        end
      end else if (m_mode == 2) begin
        m_presc = 0;
        h = m_sod / 3600;
        m = (m_sod / 60) % 60;
        if (rm) m = (m + 1) % 60;
        if (rh) h = (h + 1) % 24;
        m_sod = h * 3600 + m * 60;
      end
      m_mode = set_mode ? 2 : (run ? 1 : 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("sec",  32'(sec),  32'(m_sod % 60));
      check("min",  32'(min),  32'((m_sod / 60) % 60));
      check("hour", 32'(hour), 32'(m_sod / 3600));
      check("tick", 32'(tick), 32'(m_tick));
      check("mode", 32'(mode), 32'(m_mode));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_min(input int n);
    for (int i = 0; i < n; i++) begin
      inc_min = 1'b1; step(1);
      inc_min = 1'b0; step(1);
    end
  endtask

  task automatic pulse_hour(input int n);
    for (int i = 0; i < n; i++) begin
      inc_hour = 1'b1; step(1);
      inc_hour = 1'b0; step(1);
    end
  endtask

  initial begin
    // Reset with INC_MIN held high and SET_MODE requested
    rst_n = 1'b0; run = 1'b0; set_mode = 1'b1;
    inc_min = 1'b1; inc_hour = 1'b0; clear = 1'b0;
    step(2);
    chk = 1'b1;
    rst_n = 1'b1;
    step(3);
    check("rst_mode", 32'(mode), 32'd2);
    check("rst_min_noedge", 32'(min), 32'd0);
    check("rst_sec", 32'(sec), 32'd0);
    inc_min = 1'b0;
    step(1);

    // Preload 23:59 then run through 60 ticks
    pulse_hour(23);
    pulse_min(59);
    check("preload_hour", 32'(hour), 32'd23);
    check("preload_min", 32'(min), 32'd59);
    set_mode = 1'b0; run = 1'b1;
    step(241);
    check("carry_sec", 32'(sec), 32'd0);
    check("carry_min", 32'(min), 32'd0);
    check("carry_hour", 32'(hour), 32'd0);
    check("carry_tick", 32'(tick), 32'd1);

    // Set-mode wrap and simultaneous edges
    set_mode = 1'b1; run = 1'b0;
    step(2);
    pulse_hour(3);
    pulse_min(60);
    check("wrap_min", 32'(min), 32'd0);
    check("wrap_hour", 32'(hour), 32'd3);
    pulse_min(5);
    pulse_hour(4);
    inc_min = 1'b1; inc_hour = 1'b1; step(1);
    inc_min = 1'b0; inc_hour = 1'b0; step(1);
    check("simul_min", 32'(min), 32'd6);
    check("simul_hour", 32'(hour), 32'd8);

    // Pause keeps partial second
    set_mode = 1'b0; run = 1'b1;
    step(6);
    check("pause_sec_pre", 32'(sec), 32'd1);
    run = 1'b0;
    step(20);
    check("pause_sec", 32'(sec), 32'd1);
    check("pause_mode", 32'(mode), 32'd0);
    run = 1'b1;
    step(3);
    check("resume_tick", 32'(tick), 32'd1);
    check("resume_sec", 32'(sec), 32'd2);

    // Buttons ignored in RUN; SET zeroes seconds
    step(140);
    check("sec37", 32'(sec), 32'd37);
    pulse_min(1);
    check("run_inc_ignored", 32'(min), 32'd6);
    set_mode = 1'b1;
    step(1);
    check("set_mode2", 32'(mode), 32'd2);
    step(1);
    check("set_sec0", 32'(sec), 32'd0);

    // CLEAR on the cycle a carry would have happened
    pulse_min(53);
    set_mode = 1'b0;
    step(240);
    check("pre_clear_sec", 32'(sec), 32'd59);
    check("pre_clear_min", 32'(min), 32'd59);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear_sec", 32'(sec), 32'd0);
    check("clear_min", 32'(min), 32'd0);
    check("clear_hour", 32'(hour), 32'd0);
    check("clear_tick", 32'(tick), 32'd0);
    check("clear_mode", 32'(mode), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      clear = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) set_mode = ~set_mode;
      if ($urandom_range(0, 9) == 0) run = ~run;
      inc_min = 1'($urandom_range(0, 1));
      inc_hour = ($urandom_range(0, 3) == 0);
      step(1);
    end
    rst_n = 1'b1; clear = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
